// File: rtl/duty_button_conditioner.sv
// -----------------------------------------------------------------------------
// duty_button_conditioner
//
// Turns the two raw duty-adjust push-buttons into clean single-cycle command
// strobes for the PWM generator. Each channel (index 0 = inc, 1 = dec) has a
// two-flop synchroniser, a counter debouncer, a rising-edge detector and a
// small IDLE/HELD/REPEAT FSM that provides optional auto-repeat while the
// button is held. When both debounced levels are high together, both channels
// are frozen and muted, so the PWM generator never sees two strobes at once.
//
// Ports
//   clk            : system clock, all logic on its rising edge
//   rst_n          : asynchronous active-low reset
//   btn_inc        : raw asynchronous increase button, active-high
//   btn_dec        : raw asynchronous decrease button, active-high
//   increase_duty  : registered single-cycle increase strobe
//   decrease_duty  : registered single-cycle decrease strobe
//   inc_stable     : debounced level of btn_inc
//   dec_stable     : debounced level of btn_dec
//   dbg_inc_state  : current FSM state of the inc channel (0 IDLE, 1 HELD, 2 REPEAT)
//   dbg_dec_state  : current FSM state of the dec channel (same encoding)
// -----------------------------------------------------------------------------
module duty_button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit REPEAT_EN       = 1'b1,
   parameter int HOLD_CYCLES     = 32,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_inc,
   input  logic       btn_dec,
   output logic       increase_duty,
   output logic       decrease_duty,
   output logic       inc_stable,
   output logic       dec_stable,
   output logic [1:0] dbg_inc_state,
   output logic [1:0] dbg_dec_state
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   // Terminal values are compared one early: the cycle in which the count
   // "would reach" its limit is the cycle that acts.
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   logic [1:0]    btn;
   logic [1:0]    s1;
   logic [1:0]    s2;
   logic [1:0]    stable;
   logic [1:0]    stable_d;
   logic [1:0]    rise;
   logic [1:0]    strobe;
   logic          both;
   logic [DW-1:0] db_cnt [2];
   logic [TW-1:0] timer  [2];
   state_t        state  [2];

   assign btn  = {btn_dec, btn_inc};
   assign rise = stable & ~stable_d;
   assign both = stable[0] & stable[1];

   // Synchroniser, debouncer and edge-detect delay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= '0;
         s2       <= '0;
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         s1       <= btn;
         s2       <= s1;
         stable_d <= stable;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= s2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   // Per-channel press / hold / repeat FSM with registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strobe <= '0;
         for (int i = 0; i < 2; i++) begin
            state[i] <= IDLE;
            timer[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            strobe[i] <= 1'b0;
            if (!stable[i]) begin
               state[i] <= IDLE;
               timer[i] <= '0;
            end else if (both) begin
               // Simultaneous press: mute and freeze. A rise arriving now is
               // still consumed (IDLE -> HELD, silently) so the survivor of
               // the pair resumes hold timing instead of waiting forever.
               timer[i] <= '0;
               if (state[i] == IDLE && rise[i]) begin
                  state[i] <= HELD;
               end
            end else begin
               case (state[i])
                  IDLE: begin
                     if (rise[i]) begin
                        state[i]  <= HELD;
                        timer[i]  <= '0;
                        strobe[i] <= 1'b1;
                     end
                  end
                  HELD: begin
                     if (timer[i] == HOLD_LAST) begin
                        timer[i] <= '0;
                        if (REPEAT_EN) begin
                           state[i]  <= REPEAT;
                           strobe[i] <= 1'b1;
                        end
                     end else begin
                        timer[i] <= timer[i] + TW'(1);
                     end
                  end
                  REPEAT: begin
                     if (timer[i] == REP_LAST) begin
                        timer[i]  <= '0;
                        strobe[i] <= 1'b1;
                     end else begin
                        timer[i] <= timer[i] + TW'(1);
                     end
                  end
                  default: begin
                     state[i] <= IDLE;
                     timer[i] <= '0;
                  end
               endcase
            end
         end
      end
   end

   assign increase_duty = strobe[0];
   assign decrease_duty = strobe[1];
   assign inc_stable    = stable[0];
   assign dec_stable    = stable[1];
   assign dbg_inc_state = state[0];
   assign dbg_dec_state = state[1];

endmodule

// File: tb/tb_duty_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_duty_button_conditioner
//
// Directed bench for duty_button_conditioner. Two instances share the button
// inputs: dut (defaults, auto-repeat on) and dut_nr (REPEAT_EN = 0).
// Edge numbering inside a sequence: edge 0 is the first rising edge after the
// inputs are changed; outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_duty_button_conditioner;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_inc = 1'b0;
   logic btn_dec = 1'b0;

   always #5 clk = ~clk;

   logic       increase_duty, decrease_duty, inc_stable, dec_stable;
   logic [1:0] dbg_inc_state, dbg_dec_state;
   logic       nr_increase, nr_decrease, nr_inc_stable, nr_dec_stable;
   logic [1:0] nr_dbg_inc_state, nr_dbg_dec_state;

   duty_button_conditioner dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_inc       (btn_inc),
      .btn_dec       (btn_dec),
      .increase_duty (increase_duty),
      .decrease_duty (decrease_duty),
      .inc_stable    (inc_stable),
      .dec_stable    (dec_stable),
      .dbg_inc_state (dbg_inc_state),
      .dbg_dec_state (dbg_dec_state)
   );

   duty_button_conditioner #(.REPEAT_EN(1'b0)) dut_nr (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_inc       (btn_inc),
      .btn_dec       (btn_dec),
      .increase_duty (nr_increase),
      .decrease_duty (nr_decrease),
      .inc_stable    (nr_inc_stable),
      .dec_stable    (nr_dec_stable),
      .dbg_inc_state (nr_dbg_inc_state),
      .dbg_dec_state (nr_dbg_dec_state)
   );

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   int          edge_idx;
   int          inc_q[$];
   int          dec_q[$];
   int          nr_q[$];
   int          act_q[$];
   logic [31:0] exp_q[$];
   int          inc_rise_e, inc_fall_e, dec_rise_e, dec_fall_e;
   int          coincide, wide;
   logic        p_inc, p_dec, p_inc_st, p_dec_st;

   typedef struct {
      logic inc;
      logic dec;
      int   cycles;
      int   exp_inc_n;
      int   exp_dec_n;
      logic exp_inc_st;
      logic exp_dec_st;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_seq();
      inc_q.delete();
      dec_q.delete();
      nr_q.delete();
      exp_q.delete();
      edge_idx   = 0;
      inc_rise_e = -1;
      inc_fall_e = -1;
      dec_rise_e = -1;
      dec_fall_e = -1;
      coincide   = 0;
      wide       = 0;
      p_inc      = increase_duty;
      p_dec      = decrease_duty;
      p_inc_st   = inc_stable;
      p_dec_st   = dec_stable;
   endtask

   // Advance n edges, logging strobe edges and stable transitions.
   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         if (increase_duty) inc_q.push_back(edge_idx);
         if (decrease_duty) dec_q.push_back(edge_idx);
         if (nr_increase)   nr_q.push_back(edge_idx);
         if (increase_duty && decrease_duty) coincide++;
         if ((increase_duty && p_inc) || (decrease_duty && p_dec)) wide++;
         if (inc_stable && !p_inc_st && inc_rise_e < 0) inc_rise_e = edge_idx;
         if (!inc_stable && p_inc_st && inc_fall_e < 0) inc_fall_e = edge_idx;
         if (dec_stable && !p_dec_st && dec_rise_e < 0) dec_rise_e = edge_idx;
         if (!dec_stable && p_dec_st && dec_fall_e < 0) dec_fall_e = edge_idx;
         p_inc    = increase_duty;
         p_dec    = decrease_duty;
         p_inc_st = inc_stable;
         p_dec_st = dec_stable;
         edge_idx++;
      end
   endtask

   // Compare act_q against exp_q, element by element.
   task automatic check_q(input string name);
      check({name, " count"}, act_q.size(), exp_q.size());
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s[%0d] edge", name, i), act_q[i], int'(exp_q[i]));
      end
   endtask

   // ---------------- test ----------------
   initial begin
      // {inc, dec, cycles, inc pulses, dec pulses, inc_stable at end, dec_stable at end}
      vecs[0]  = '{1'b0, 1'b0, 10, 0, 0, 1'b0, 1'b0}; // idle
      vecs[1]  = '{1'b1, 1'b0,  3, 0, 0, 1'b0, 1'b0}; // 3-cycle glitch
      vecs[2]  = '{1'b0, 1'b0, 10, 0, 0, 1'b0, 1'b0}; // glitch rejected
      vecs[3]  = '{1'b1, 1'b0,  4, 0, 0, 1'b0, 1'b0}; // 4-cycle press (threshold)
      vecs[4]  = '{1'b0, 1'b0, 12, 1, 0, 1'b0, 1'b0}; // accepted: strobe at edge 6
      vecs[5]  = '{1'b0, 1'b1, 10, 0, 1, 1'b0, 1'b1}; // dec press
      vecs[6]  = '{1'b0, 1'b0, 10, 0, 0, 1'b0, 1'b0}; // dec release
      vecs[7]  = '{1'b1, 1'b0,  8, 1, 0, 1'b1, 1'b0}; // inc press, held
      vecs[8]  = '{1'b1, 1'b1, 40, 0, 0, 1'b1, 1'b1}; // dec joins: all muted
      vecs[9]  = '{1'b1, 1'b0, 20, 0, 0, 1'b1, 1'b0}; // dec leaves, hold restarts
      vecs[10] = '{1'b0, 1'b0, 12, 0, 0, 1'b0, 1'b0}; // release before hold expires

      // ---- reset with buttons toggling ----
      rst_n = 1'b0;
      for (int k = 0; k < 8; k++) begin
         btn_inc = k[0];
         btn_dec = ~k[0];
         step();
         check($sformatf("reset outs dut k%0d", k),
               int'({increase_duty, decrease_duty, inc_stable, dec_stable}), 0);
         check($sformatf("reset outs nr k%0d", k),
               int'({nr_increase, nr_decrease, nr_inc_stable, nr_dec_stable}), 0);
      end
      btn_inc = 1'b0;
      btn_dec = 1'b0;
      step();
      rst_n = 1'b1;
      begin_seq();
      run(10);

      // ---- table-driven vectors ----
      for (int v = 0; v < 11; v++) begin
         btn_inc = vecs[v].inc;
         btn_dec = vecs[v].dec;
         begin_seq();
         run(vecs[v].cycles);
         check($sformatf("vec%0d inc pulses", v), inc_q.size(), vecs[v].exp_inc_n);
         check($sformatf("vec%0d dec pulses", v), dec_q.size(), vecs[v].exp_dec_n);
         check($sformatf("vec%0d inc_stable", v), int'(inc_stable), int'(vecs[v].exp_inc_st));
         check($sformatf("vec%0d dec_stable", v), int'(dec_stable), int'(vecs[v].exp_dec_st));
      end

      // ---- single press, 10 cycles ----
      begin_seq();
      btn_inc = 1'b1;
      run(10);
      btn_inc = 1'b0;
      run(15);
      act_q = inc_q; exp_q.delete(); exp_q.push_back(6);
      check_q("single inc");
      act_q = dec_q; exp_q.delete();
      check_q("single dec");
      check("single inc_stable rise edge", inc_rise_e, 5);
      check("single inc_stable fall edge", inc_fall_e, 15);
      check("single strobe width", wide, 0);

      // ---- bounce rejection on dec ----
      begin_seq();
      for (int k = 0; k < 40; k++) begin
         btn_dec = ((k / 2) % 2 == 0);
         run(1);
      end
      btn_dec = 1'b1;
      run(20);
      btn_dec = 1'b0;
      run(10);
      act_q = dec_q; exp_q.delete(); exp_q.push_back(46);
      check_q("bounce dec");
      check("bounce dec_stable rise edge", dec_rise_e, 45);
      check("bounce inc pulses", inc_q.size(), 0);

      // ---- auto-repeat, held 100 cycles ----
      // The release needs 6 edges to reach the FSM, so the repeat due at
      // edge 102 still fires after the button is let go at edge 100.
      begin_seq();
      btn_inc = 1'b1;
      run(100);
      check("repeat dut state", int'(dbg_inc_state), 2);
      check("repeat nr state", int'(nr_dbg_inc_state), 1);
      check("repeat nr dec state", int'(nr_dbg_dec_state), 0);
      btn_inc = 1'b0;
      run(20);
      act_q = inc_q; exp_q.delete();
      exp_q.push_back(6);  exp_q.push_back(38); exp_q.push_back(54);
      exp_q.push_back(70); exp_q.push_back(86); exp_q.push_back(102);
      check_q("repeat inc");
      act_q = nr_q; exp_q.delete(); exp_q.push_back(6);
      check_q("norepeat inc");
      check("repeat strobe width", wide, 0);

      // ---- simultaneous press ----
      begin_seq();
      btn_inc = 1'b1;
      btn_dec = 1'b1;
      run(60);
      check("simul stables", int'({inc_stable, dec_stable}), 3);
      check("simul inc state", int'(dbg_inc_state), 1);
      check("simul dec state", int'(dbg_dec_state), 1);
      btn_dec = 1'b0;
      run(56);
      btn_inc = 1'b0;
      run(20);
      check("simul dec_stable fall edge", dec_fall_e, 65);
      act_q = inc_q; exp_q.delete(); exp_q.push_back(97); exp_q.push_back(113);
      check_q("simul inc");
      act_q = dec_q; exp_q.delete();
      check_q("simul dec");
      check("simul coincident strobes", coincide, 0);

      // ---- reset mid-hold ----
      begin_seq();
      btn_inc = 1'b1;
      run(45);
      check("midhold inc_stable before reset", int'(inc_stable), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset outs", int'({increase_duty, decrease_duty, inc_stable, dec_stable}), 0);
      check("async reset state", int'(dbg_inc_state), 0);
      run(3);
      rst_n = 1'b1;
      run(63);
      btn_inc = 1'b0;
      run(20);
      act_q = inc_q; exp_q.delete();
      exp_q.push_back(6);  exp_q.push_back(38); exp_q.push_back(54);
      exp_q.push_back(86); exp_q.push_back(102);
      check_q("midhold inc");
      check("midhold dec pulses", dec_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
